// File: rtl/people_counter_if.sv
// Sensor inputs and occupancy/event outputs of the door-sensor front end.
// The bench drives through master; the counter sits on slave.
interface people_counter_if #(
    parameter int N = 3
) ();
    logic         front_sensor;
    logic         back_sensor;
    logic [N-1:0] Pcount;
    logic         arrive_pulse;
    logic         depart_pulse;
    logic         reject_full;
    logic         underflow_err;

    modport master (
        output front_sensor, back_sensor,
        input  Pcount, arrive_pulse, depart_pulse, reject_full, underflow_err
    );

    modport slave (
        input  front_sensor, back_sensor,
        output Pcount, arrive_pulse, depart_pulse, reject_full, underflow_err
    );
endinterface

// File: rtl/people_counter.sv
// Door photocell front end: per-sensor sync + debounce producing one-cycle events,
// feeding a saturating occupancy counter with full/empty error pulses.

module people_counter_deb #(
    parameter int DEB = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic pulse
);
    localparam int CW = $clog2(DEB + 1);
    localparam logic [CW-1:0] DEB_C = CW'(DEB);

    typedef enum logic [1:0] {IDLE, RISE_WAIT, HIGH, FALL_WAIT} deb_state_e;

    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    sync_pipe;
    logic          s, pulse_d;

    assign s       = sync_pipe[1];
    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_pipe <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            pulse     <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], sensor};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse     <= pulse_d;
        end
    end

    // The pulse fires only on the RISE_WAIT->HIGH step, so a bounce back from
    // FALL_WAIT into HIGH never produces a second event.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = RISE_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            RISE_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_C) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = FALL_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            FALL_WAIT: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

module people_counter #(
    parameter int N   = 3,
    parameter int DEB = 4
) (
    input logic          clk,
    input logic          reset,
    people_counter_if.slave bus
);
    localparam int NUM_LANES = 2;   // lane 0 = front (arrive), lane 1 = back (depart)
    localparam logic [N-1:0] MAX = {N{1'b1}};

    logic [NUM_LANES-1:0] sensor, pulse;
    logic [N-1:0]         pcount_q;
    logic                 reject_q, underflow_q;

    assign sensor = {bus.back_sensor, bus.front_sensor};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        people_counter_deb #(.DEB(DEB)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .sensor (sensor[g]),
            .pulse  (pulse[g])
        );
    end

    // Simultaneous arrive+depart cancels out, even at the saturation limits.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcount_q    <= '0;
            reject_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            reject_q    <= 1'b0;
            underflow_q <= 1'b0;
            case (pulse)
                2'b01: begin
                    if (pcount_q == MAX) reject_q <= 1'b1;
                    else                 pcount_q <= pcount_q + N'(1);
                end
                2'b10: begin
                    if (pcount_q == '0) underflow_q <= 1'b1;
                    else                pcount_q    <= pcount_q - N'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.Pcount        = pcount_q;
    assign bus.arrive_pulse  = pulse[0];
    assign bus.depart_pulse  = pulse[1];
    assign bus.reject_full   = reject_q;
    assign bus.underflow_err = underflow_q;
endmodule

// File: tb/tb_people_counter.sv
// Table-driven bench for people_counter: each vector pushes its expected events
// into a scoreboard that a negedge monitor pops whenever the DUT shows activity.
module tb_people_counter;
    localparam int N   = 3;
    localparam int DEB = 4;

    typedef struct {
        int         cyc;
        logic       arr, dep, rej, und;
        logic [2:0] pc;
    } ev_t;

    typedef struct {
        bit         f, b;
        int         hi;
        logic       arr, dep, rej, und;
        logic [2:0] pc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] exp_pc = 3'd0;
    logic [2:0] last_pc = 3'd0;
    ev_t  sb[$];

    people_counter_if #(.N(N)) bus ();

    people_counter #(.N(N), .DEB(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: every cycle with a pulse or a Pcount change must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            last_pc = bus.Pcount;
        end else if (bus.arrive_pulse || bus.depart_pulse || bus.reject_full ||
                     bus.underflow_err || bus.Pcount != last_pc) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got arr=%0b dep=%0b rej=%0b und=%0b pc=%0d",
                         cyc, bus.arrive_pulse, bus.depart_pulse, bus.reject_full,
                         bus.underflow_err, bus.Pcount);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.arr !== bus.arrive_pulse || e.dep !== bus.depart_pulse ||
                    e.rej !== bus.reject_full || e.und !== bus.underflow_err || e.pc !== bus.Pcount) begin
                    errors++;
                    $display("FAIL event got cyc=%0d arr=%0b dep=%0b rej=%0b und=%0b pc=%0d exp cyc=%0d arr=%0b dep=%0b rej=%0b und=%0b pc=%0d",
                             cyc, bus.arrive_pulse, bus.depart_pulse, bus.reject_full,
                             bus.underflow_err, bus.Pcount, e.cyc, e.arr, e.dep, e.rej, e.und, e.pc);
                end
            end
            last_pc = bus.Pcount;
        end
    end

    task automatic check_pc(input string name, input logic [2:0] exp);
        checks++;
        if (bus.Pcount !== exp) begin
            errors++;
            $display("FAIL %s Pcount got %0d exp %0d", name, bus.Pcount, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (bus.Pcount !== 3'd0 || bus.arrive_pulse !== 1'b0 || bus.depart_pulse !== 1'b0 ||
            bus.reject_full !== 1'b0 || bus.underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL %s got pc=%0d arr=%0b dep=%0b rej=%0b und=%0b exp all 0",
                     name, bus.Pcount, bus.arrive_pulse, bus.depart_pulse,
                     bus.reject_full, bus.underflow_err);
        end
    endtask

    // Sensor(s) high for v.hi cycles starting at edge t0; pulse expected in cycle t0+DEB+1,
    // counter result in cycle t0+DEB+2.
    task automatic run_row(input vec_t v);
        int t0;
        @(negedge clk); #1;
        t0 = cyc + 1;
        if (v.arr || v.dep)
            sb.push_back(ev_t'{t0 + DEB + 1, v.arr, v.dep, 1'b0, 1'b0, exp_pc});
        if (v.rej || v.und || v.pc != exp_pc)
            sb.push_back(ev_t'{t0 + DEB + 2, 1'b0, 1'b0, v.rej, v.und, v.pc});
        bus.front_sensor = v.f;
        bus.back_sensor  = v.b;
        repeat (v.hi) @(negedge clk);
        #1;
        bus.front_sensor = 1'b0;
        bus.back_sensor  = 1'b0;
        repeat (DEB + 10) @(negedge clk);
        check_pc("row_pcount", v.pc);
        exp_pc = v.pc;
    endtask

    initial begin
        vec_t tbl[$];
        int   t0;

        // f, b, hi, arr, dep, rej, und, pc-after
        tbl.push_back(vec_t'{1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0});
        for (int i = 0; i < 5; i++)
            tbl.push_back(vec_t'{1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1});
        for (int i = 2; i <= 7; i++)
            tbl.push_back(vec_t'{1'b1, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0, 3'(i)});
        tbl.push_back(vec_t'{1'b1, 1'b0, 6, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7});
        tbl.push_back(vec_t'{1'b1, 1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7});
        for (int i = 6; i >= 3; i--)
            tbl.push_back(vec_t'{1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0, 3'(i)});
        tbl.push_back(vec_t'{1'b1, 1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3});

        bus.front_sensor = 1'b0;
        bus.back_sensor  = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("post_reset_idle");

        foreach (tbl[i]) run_row(tbl[i]);

        // 20-cycle front pulse with a 2-cycle dropout: exactly one arrival
        @(negedge clk); #1;
        t0 = cyc + 1;
        sb.push_back(ev_t'{t0 + DEB + 1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3});
        sb.push_back(ev_t'{t0 + DEB + 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4});
        bus.front_sensor = 1'b1;
        repeat (8) @(negedge clk);
        #1 bus.front_sensor = 1'b0;
        repeat (2) @(negedge clk);
        #1 bus.front_sensor = 1'b1;
        repeat (10) @(negedge clk);
        #1 bus.front_sensor = 1'b0;
        repeat (DEB + 10) @(negedge clk);
        check_pc("dropout_pcount", 3'd4);
        exp_pc = 3'd4;

        run_row(vec_t'{1'b1, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5});

        // Reset lands on the arrive_pulse cycle at Pcount=5; front stays high through release
        @(negedge clk); #1;
        t0 = cyc + 1;
        sb.push_back(ev_t'{t0 + DEB + 1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5});
        bus.front_sensor = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        checks++;
        if (bus.arrive_pulse !== 1'b1) begin
            errors++;
            $display("FAIL reset_pulse_cycle arrive_pulse got %0b exp 1", bus.arrive_pulse);
        end
        #1 reset = 1'b1;
        @(negedge clk);
        check_quiet("reset_discards_pulse");
        #1 reset = 1'b0;
        t0 = cyc + 1;
        sb.push_back(ev_t'{t0 + DEB + 1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
        sb.push_back(ev_t'{t0 + DEB + 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1});
        repeat (10) @(negedge clk);
        #1 bus.front_sensor = 1'b0;
        repeat (DEB + 10) @(negedge clk);
        check_pc("held_through_reset", 3'd1);

        repeat (20) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending got %0d exp 0 (next cyc=%0d)", sb.size(), sb[0].cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
